// File: rtl/tcon_word_assembler_pkg.sv
// Shared definitions for the tcon word-transfer receive path.
package tcon_pkg;

  localparam int TCON_WORD_W = 8;

  typedef logic [TCON_WORD_W-1:0] tcon_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } asm_state_e;

endpackage

// File: rtl/tcon_word_assembler_fifo.sv
// Small synchronous FIFO holding assembled words; pointers carry one extra wrap bit.
module tcon_word_fifo
  import tcon_pkg::*;
#(
  parameter int WIDTH = TCON_WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign level    = wr_ptr_r - rd_ptr_r;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign wr_en_s  = push && (!full || pop);
  assign rd_en_s  = pop && !empty;
  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/tcon_word_assembler.sv
// Serial-to-parallel word assembler: MSB-first shift, sync re-alignment, buffered word output.
module tcon_word_assembler
  import tcon_pkg::*;
#(
  parameter int WIDTH = TCON_WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin_valid,
  input  logic                     sin_bit,
  output logic                     sin_ready,
  input  logic                     sync,
  output logic                     word_valid,
  output logic [WIDTH-1:0]         word_data,
  input  logic                     word_ready,
  output logic                     partial_err,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    bit_cnt_r;
  asm_state_e       state_r;
  logic             partial_err_r;

  logic [WIDTH-1:0] shift_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  asm_state_e       state_nxt_s;
  logic [LW-1:0]    level_nxt_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // STALL means the last bit is pending against a full FIFO; a same-cycle pop frees it.
  assign sin_ready   = !((state_r == STALL) && !pop_s);
  assign accept_s    = sin_valid && sin_ready;
  assign word_valid  = !fifo_empty_s;
  assign pop_s       = word_valid && word_ready;
  assign partial_err = partial_err_r;

  // Next shift/count values; sync overrides word completion
  always_comb begin
    shift_nxt_s = shift_r;
    cnt_nxt_s   = bit_cnt_r;
    push_s      = 1'b0;
    if (sync) begin
      if (accept_s) begin
        shift_nxt_s = {{(WIDTH-1){1'b0}}, sin_bit};
        cnt_nxt_s   = CNT_ONE;
      end else begin
        shift_nxt_s = {WIDTH{1'b0}};
        cnt_nxt_s   = {CW{1'b0}};
      end
    end else if (accept_s) begin
      shift_nxt_s = {shift_r[WIDTH-2:0], sin_bit};
      if (bit_cnt_r == LAST_CNT) begin
        push_s    = 1'b1;
        cnt_nxt_s = {CW{1'b0}};
      end else begin
        cnt_nxt_s = bit_cnt_r + CNT_ONE;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Next FSM state from the post-edge counter and FIFO occupancy
  always_comb begin
    level_nxt_s = level + LW'(push_s) - LW'(pop_s);
    if (cnt_nxt_s == {CW{1'b0}}) begin
      state_nxt_s = IDLE;
    end else if ((cnt_nxt_s == LAST_CNT) && (level_nxt_s == FULL_LVL)) begin
      state_nxt_s = STALL;
    end else begin
      state_nxt_s = SHIFT;
    end
  end

  // Shift register, bit counter, FSM state and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r       <= {WIDTH{1'b0}};
      bit_cnt_r     <= {CW{1'b0}};
      state_r       <= IDLE;
      partial_err_r <= 1'b0;
    end else begin
      shift_r       <= shift_nxt_s;
      bit_cnt_r     <= cnt_nxt_s;
      state_r       <= state_nxt_s;
      partial_err_r <= sync && (bit_cnt_r != {CW{1'b0}});
    end
  end

  tcon_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (shift_nxt_s),
    .pop       (pop_s),
    .pop_data  (word_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (level)
  );

endmodule

// File: tb/tb_tcon_word_assembler.sv
// Directed and randomized-gap bench for tcon_word_assembler (WIDTH=8, DEPTH=2).
module tb_tcon_word_assembler;

  logic       clk;
  logic       rst;
  logic       sin_valid;
  logic       sin_bit;
  logic       sin_ready;
  logic       sync;
  logic       word_valid;
  logic [7:0] word_data;
  logic       word_ready;
  logic       partial_err;
  logic [1:0] level;

  int n_cmp;
  int n_err;

  tcon_word_assembler #(.WIDTH(8), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sin_valid   (sin_valid),
    .sin_bit     (sin_bit),
    .sin_ready   (sin_ready),
    .sync        (sync),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .partial_err (partial_err),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one bit and let one rising edge pass; called at a falling edge.
  task automatic drive_bit(input logic b);
    sin_valid = 1'b1;
    sin_bit   = b;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", word_valid); end
    n_cmp++; if (word_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", word_data); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (partial_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", partial_err); end
    n_cmp++; if (sin_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", sin_ready); end
  endtask

  task automatic test_basic_word();
    word_ready = 1'b1;
    send_word(8'hA5);
    sin_valid = 1'b0;
    n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b want 1", word_valid); end
    n_cmp++; if (word_data !== 8'hA5) begin n_err++; $display("FAIL t1_data: got %h want a5", word_data); end
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL t1_level1: got %0d want 1", level); end
    @(negedge clk);
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_drop: got %b want 0", word_valid); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL t1_level0: got %0d want 0", level); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w33;
    w33 = 8'h33;
    word_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    for (int i = 7; i >= 1; i--) drive_bit(w33[i]);
    sin_bit = w33[0];
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL t2_level_full: got %0d want 2", level); end
    n_cmp++; if (sin_ready !== 1'b0) begin n_err++; $display("FAIL t2_stall: got %b want 0", sin_ready); end
    n_cmp++; if (word_data !== 8'h11) begin n_err++; $display("FAIL t2_head11: got %h want 11", word_data); end
    @(negedge clk);
    n_cmp++; if (sin_ready !== 1'b0) begin n_err++; $display("FAIL t2_stall_hold: got %b want 0", sin_ready); end
    word_ready = 1'b1;
    #1;
    n_cmp++; if (sin_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_on_pop: got %b want 1", sin_ready); end
    @(negedge clk);
    sin_valid = 1'b0;
    n_cmp++; if (word_data !== 8'h22) begin n_err++; $display("FAIL t2_head22: got %h want 22", word_data); end
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL t2_level_pushpop: got %0d want 2", level); end
    @(negedge clk);
    n_cmp++; if (word_data !== 8'h33) begin n_err++; $display("FAIL t2_head33: got %h want 33", word_data); end
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL t2_level1: got %0d want 1", level); end
    @(negedge clk);
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL t2_drained: got %b want 0", word_valid); end
  endtask

  task automatic test_sync_partial();
    word_ready = 1'b1;
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    sin_valid = 1'b0;
    sync = 1'b1;
    #1;
    n_cmp++; if (partial_err !== 1'b0) begin n_err++; $display("FAIL t3_perr_early: got %b want 0", partial_err); end
    @(negedge clk);
    sync = 1'b0;
    n_cmp++; if (partial_err !== 1'b1) begin n_err++; $display("FAIL t3_perr_pulse: got %b want 1", partial_err); end
    @(negedge clk);
    n_cmp++; if (partial_err !== 1'b0) begin n_err++; $display("FAIL t3_perr_once: got %b want 0", partial_err); end
    send_word(8'hC3);
    sin_valid = 1'b0;
    n_cmp++; if (word_data !== 8'hC3) begin n_err++; $display("FAIL t3_data: got %h want c3", word_data); end
    n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL t3_valid: got %b want 1", word_valid); end
    @(negedge clk);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL t3_level0: got %0d want 0", level); end
  endtask

  task automatic test_sync_with_bit();
    word_ready = 1'b1;
    sync = 1'b1;
    drive_bit(1'b1);
    sync = 1'b0;
    n_cmp++; if (partial_err !== 1'b0) begin n_err++; $display("FAIL t4_perr_cnt0: got %b want 0", partial_err); end
    for (int i = 0; i < 7; i++) drive_bit(1'b0);
    sin_valid = 1'b0;
    n_cmp++; if (word_data !== 8'h80) begin n_err++; $display("FAIL t4_data80: got %h want 80", word_data); end
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    n_cmp++; if (partial_err !== 1'b0) begin n_err++; $display("FAIL t4_sync_noop: got %b want 0", partial_err); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL t4_level0: got %0d want 0", level); end
    // sync lands on the edge that would complete a word: no push, bit restarts the word
    for (int i = 0; i < 7; i++) drive_bit(1'b1);
    sync = 1'b1;
    drive_bit(1'b1);
    sync = 1'b0;
    sin_valid = 1'b0;
    n_cmp++; if (partial_err !== 1'b1) begin n_err++; $display("FAIL t4_perr_last: got %b want 1", partial_err); end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL t4_no_push: got %b want 0", word_valid); end
    for (int i = 0; i < 7; i++) drive_bit(1'b0);
    sin_valid = 1'b0;
    n_cmp++; if (word_data !== 8'h80) begin n_err++; $display("FAIL t4_realign: got %h want 80", word_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_midword();
    word_ready = 1'b0;
    send_word(8'h5A);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    sin_valid = 1'b0;
    n_cmp++; if (level !== 2'd1) begin n_err++; $display("FAIL t5_pre_level: got %0d want 1", level); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL t5_valid: got %b want 0", word_valid); end
    n_cmp++; if (word_data !== 8'h00) begin n_err++; $display("FAIL t5_data: got %h want 00", word_data); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL t5_level: got %0d want 0", level); end
    n_cmp++; if (partial_err !== 1'b0) begin n_err++; $display("FAIL t5_perr: got %b want 0", partial_err); end
    n_cmp++; if (sin_ready !== 1'b1) begin n_err++; $display("FAIL t5_ready: got %b want 1", sin_ready); end
    word_ready = 1'b1;
    send_word(8'h3C);
    sin_valid = 1'b0;
    n_cmp++; if (word_data !== 8'h3C) begin n_err++; $display("FAIL t5_after_data: got %h want 3c", word_data); end
    @(negedge clk);
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL t5_after_level: got %0d want 0", level); end
  endtask

  task automatic test_random_gaps();
    logic [7:0] sb_q[$];
    logic [7:0] cur_w;
    int bit_i, sent, got, cyc;
    cur_w = 8'($urandom);
    bit_i = 7; sent = 0; got = 0; cyc = 0;
    while ((got < 1000) && (cyc < 60000)) begin
      @(negedge clk);
      cyc++;
      sin_valid  = (sent < 1000) && ($urandom_range(3, 0) != 0);
      sin_bit    = cur_w[bit_i];
      word_ready = ($urandom_range(1, 0) == 1);
      #1;
      // Head must equal the oldest outstanding word every cycle, which also covers stability
      if (word_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++; $display("FAIL t6_dup: got %h want no word", word_data);
        end else if (word_data !== sb_q[0]) begin
          n_err++; $display("FAIL t6_data: got %h want %h", word_data, sb_q[0]);
        end
        if (word_ready && (sb_q.size() != 0)) begin
          void'(sb_q.pop_front());
          got++;
        end
      end
      if (sin_valid && sin_ready) begin
        if (bit_i == 0) begin
          sb_q.push_back(cur_w);
          sent++;
          cur_w = 8'($urandom);
          bit_i = 7;
        end else begin
          bit_i--;
        end
      end
    end
    sin_valid = 1'b0;
    word_ready = 1'b0;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL t6_count: got %0d want 1000 (cycles %0d)", got, cyc); end
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL t6_leftover: got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; sin_valid = 1'b0; sin_bit = 1'b0; sync = 1'b0; word_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_word();
    test_backpressure();
    test_sync_partial();
    test_sync_with_bit();
    test_reset_midword();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
